event_frame_builder: RTL
========================

# event_frame_builder

Packs the per-event stream from the L1 event buffer into 40-bit frame words (header, hit data, trailer) and queues them in an internal stream FIFO for the serializer. It is the stage directly downstream of the L1 event buffer and drives the `streamBufAlmostFull` back-pressure signal that the buffer consumes. The output side is a ready/valid word interface with first-word fall-through.

## Interface
- `DEPTH`, 64: stream FIFO depth in 40-bit words; must be a power of 2, ≥16.
- `AF_MARGIN`, 8: `streamBufAlmostFull` asserts when occupancy ≥ DEPTH−AF_MARGIN; must be ≥4.
- `clk` in 1: 40 MHz clock, all logic on the rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `eventStart` in 1: one-cycle pulse that opens a new event.
- `BCIDin` in 12: event BCID; valid in the `eventStart` cycle.
- `hit` in 1: qualifies `pixelID`/`TDCData` in the same cycle.
- `pixelID` in 8: pixel address of the hit.
- `TDCData` in 29: TDC payload of the hit.
- `dout` out 40: FIFO head word.
- `dout_valid` out 1: FIFO not empty.
- `dout_ready` in 1: consumer pops the head on `dout_valid & dout_ready`.
- `streamBufAlmostFull` out 1: registered occupancy ≥ DEPTH−AF_MARGIN.
- `frameErr` out 1: sticky; set by a dropped header or trailer, or a forced close; cleared only by reset.
- `dropCount` out 16: saturating count of dropped data words.

## Operation
- Word formats, bits [39:0]:
  - Header: {2'b10, 4'hA, evtNum[7:0], BCID[11:0], 14'd0}.
  - Data: {2'b01, pixelID[7:0], TDCData[28:0], 1'b0}.
  - Trailer: {2'b11, hitCnt[8:0], forced, trunc, 19'd0, crc[7:0]}.
- State machine: IDLE and OPEN.
- IDLE, `eventStart`=1: write header, clear hitCnt/trunc, go to OPEN. `evtNum` increments (8-bit wrap) after each header.
- OPEN, `eventStart`=0:
  - `hit`=1: write data word; hitCnt+1, saturating at 511.
  - `hit`=0: write trailer with forced=0; go to IDLE.
- OPEN, `eventStart`=1 (forced close): write trailer with forced=1 and set `frameErr`. The new header goes into the one-deep `hdrPend` and is written next cycle; stay OPEN for the new event.
- In the `hdrPend` write cycle, a concurrent `hit` is dropped: trunc=1 for the new event and `dropCount`+1.
- `hit` in IDLE is ignored and not counted.
- Data word admission: written only if occupancy < DEPTH−2, which reserves two slots for trailer and next header. Otherwise dropped: trunc=1, `dropCount`+1, hitCnt still increments.
- Header or trailer with FIFO full: dropped, `frameErr`=1.
- At most one FIFO write per cycle. A push and pop in the same cycle leave occupancy unchanged.
- Reset mid-event: the FIFO is flushed and the state machine returns to IDLE. No trailer is emitted for the open event.

## Timing
- Reset values: `dout`=0, `dout_valid`=0, `streamBufAlmostFull`=0, `frameErr`=0, `dropCount`=0, `evtNum`=0, state IDLE, `hdrPend` empty.
- Input-to-output latency: a word written at edge N is on `dout` with `dout_valid`=1 after edge N if the FIFO was empty. Otherwise it appears behind the queued words.
- `streamBufAlmostFull` is computed from post-edge occupancy and updates at the same edge as the write or pop.
- Minimum frame: header at `eventStart` edge, trailer one cycle later (zero hits); hitCnt=0.

## Configuration
- `FRAME_CRC_EN` defined: trailer crc = CRC-8, polynomial 0x07, init 0x00, MSB-first over all 40 bits of every written header and data word of the frame. Dropped words are excluded.
- `FRAME_CRC_EN` undefined: crc field is 8'd0 and no CRC logic is built.

## Structure
- Shared package `etroc_frame_pkg`:
  - word-type codes (2'b10, 2'b01, 2'b11);
  - header magic 4'hA;
  - field offsets;
  - the 40-bit word typedef.
- Sub-module `frame_crc8`: one-cycle 40-bit-per-step CRC-8 update, instantiated only under `FRAME_CRC_EN`.
- The FIFO is inline: register array, read and write pointers, occupancy counter of width $clog2(DEPTH)+1.

## Test plan
- Event with BCID=0x123 and 3 hits (pixelID 0,1,2; TDCData 0x0A90A9), `dout_ready`=1 → header, 3 data words, then trailer with hitCnt=3, forced=0, trunc=0; evtNum=0.
- Zero-hit event → header followed next cycle by trailer with hitCnt=0; `streamBufAlmostFull` stays 0.
- `dout_ready`=0 with DEPTH=64, one 70-hit event → `streamBufAlmostFull` rises at occupancy 56. Data words stop at occupancy 62; `dropCount`=9. Trailer has hitCnt=70, trunc=1; final occupancy 63.
- `eventStart` while OPEN → trailer with forced=1, `frameErr`=1, new header one cycle later. A hit in that cycle is dropped and the new event's trailer has trunc=1.
- 256 zero-hit events → header evtNum wraps from 255 to 0.
- With `FRAME_CRC_EN`, a 1-hit event → trailer crc matches the golden CRC-8/0x07 computed over the header and data words. Without the macro the crc field is 0.

Source files
------------

// File: rtl/etroc_frame_pkg.sv
// Frame word layout shared by the event frame builder and its CRC helper.
package etroc_frame_pkg;

    typedef logic [39:0] word_t;

    typedef enum logic {
        ST_IDLE,
        ST_OPEN
    } state_t;

    localparam logic [1:0] TYPE_HDR  = 2'b10;
    localparam logic [1:0] TYPE_DATA = 2'b01;
    localparam logic [1:0] TYPE_TRL  = 2'b11;
    localparam logic [3:0] HDR_MAGIC = 4'hA;

    localparam int TYPE_LSB       = 38;
    localparam int HDR_MAGIC_LSB  = 34;
    localparam int HDR_EVT_LSB    = 26;
    localparam int HDR_BCID_LSB   = 14;
    localparam int DATA_PIX_LSB   = 30;
    localparam int DATA_TDC_LSB   = 1;
    localparam int TRL_CNT_LSB    = 29;
    localparam int TRL_FORCED_BIT = 28;
    localparam int TRL_TRUNC_BIT  = 27;
    localparam int TRL_CRC_LSB    = 0;

    function automatic word_t make_header(input logic [7:0] evt, input logic [11:0] bcid);
        word_t w;
        w = '0;
        w[TYPE_LSB +: 2]      = TYPE_HDR;
        w[HDR_MAGIC_LSB +: 4] = HDR_MAGIC;
        w[HDR_EVT_LSB +: 8]   = evt;
        w[HDR_BCID_LSB +: 12] = bcid;
        return w;
    endfunction

    function automatic word_t make_data(input logic [7:0] pix, input logic [28:0] tdc);
        word_t w;
        w = '0;
        w[TYPE_LSB +: 2]      = TYPE_DATA;
        w[DATA_PIX_LSB +: 8]  = pix;
        w[DATA_TDC_LSB +: 29] = tdc;
        return w;
    endfunction

    function automatic word_t make_trailer(input logic [8:0] cnt, input logic forced,
                                           input logic trunc, input logic [7:0] crc);
        word_t w;
        w = '0;
        w[TYPE_LSB +: 2]     = TYPE_TRL;
        w[TRL_CNT_LSB +: 9]  = cnt;
        w[TRL_FORCED_BIT]    = forced;
        w[TRL_TRUNC_BIT]     = trunc;
        w[TRL_CRC_LSB +: 8]  = crc;
        return w;
    endfunction

endpackage

// File: rtl/frame_crc8.sv
// CRC-8 (poly 0x07, MSB first) advanced over one 40-bit word; purely combinational.
module frame_crc8
    import etroc_frame_pkg::*;
(
    input  logic [7:0] crc_in,
    input  word_t      data,
    output logic [7:0] crc_out
);

    logic [7:0] c;
    logic       fb;

    always_comb begin
        c  = crc_in;
        fb = 1'b0;
        for (int i = 39; i >= 0; i--) begin
            fb = c[7] ^ data[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        crc_out = c;
    end

endmodule

// File: rtl/event_frame_builder.sv
// Packs L1 events into header/data/trailer words in a FWFT FIFO; a written word is on dout after its edge when empty.
// Backpressure: dout_ready pops the head; streamBufAlmostFull tells upstream to slow down. FRAME_CRC_EN adds trailer CRC.
module event_frame_builder
    import etroc_frame_pkg::*;
#(
    parameter int DEPTH     = 64,
    parameter int AF_MARGIN = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        eventStart,
    input  logic [11:0] BCIDin,
    input  logic        hit,
    input  logic [7:0]  pixelID,
    input  logic [28:0] TDCData,
    output logic [39:0] dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        streamBufAlmostFull,
    output logic        frameErr,
    output logic [15:0] dropCount
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] LVL_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] LVL_DATA = CW'(DEPTH - 2);
    localparam logic [CW-1:0] LVL_AF   = CW'(DEPTH - AF_MARGIN);

    word_t          mem [DEPTH];
    logic [AW-1:0]  wptr, rptr;
    logic [CW-1:0]  count, count_nxt;
    logic           push, pop, almost_full;

    state_t         state;
    logic           hdr_pend;
    logic [11:0]    pend_bcid;
    logic [7:0]     evt_num;
    logic [8:0]     hit_cnt;
    logic           trunc, frame_err;
    logic [15:0]    drop_cnt;

    logic           hdr_now, data_now, trl_now, forced, lost_start;
    logic [11:0]    hdr_bcid;
    word_t          wr_word;
    logic [7:0]     crc_field;

    always_comb begin
        hdr_now    = 1'b0;
        data_now   = 1'b0;
        trl_now    = 1'b0;
        forced     = 1'b0;
        lost_start = 1'b0;
        hdr_bcid   = BCIDin;
        case (state)
            ST_IDLE: hdr_now = eventStart;
            ST_OPEN: begin
                if (hdr_pend) begin
                    // The held-over header owns this cycle; a second start here cannot be framed.
                    hdr_now    = 1'b1;
                    hdr_bcid   = pend_bcid;
                    lost_start = eventStart;
                end else if (eventStart) begin
                    trl_now = 1'b1;
                    forced  = 1'b1;
                end else if (hit) begin
                    data_now = 1'b1;
                end else begin
                    trl_now = 1'b1;
                end
            end
            default: ;
        endcase

        if (hdr_now)
            wr_word = make_header(evt_num, hdr_bcid);
        else if (data_now)
            wr_word = make_data(pixelID, TDCData);
        else
            wr_word = make_trailer(hit_cnt, forced, trunc, crc_field);

        // Data stops two short of full so the trailer and the next header always fit.
        push      = data_now ? (count < LVL_DATA) : ((hdr_now || trl_now) && (count != LVL_FULL));
        pop       = (count != '0) && dout_ready;
        count_nxt = count + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= wr_word;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            hdr_pend    <= 1'b0;
            pend_bcid   <= '0;
            evt_num     <= '0;
            hit_cnt     <= '0;
            trunc       <= 1'b0;
            frame_err   <= 1'b0;
            drop_cnt    <= '0;
            count       <= '0;
            wptr        <= '0;
            rptr        <= '0;
            almost_full <= 1'b0;
        end else begin
            count       <= count_nxt;
            almost_full <= (count_nxt >= LVL_AF);
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            if (((hdr_now || trl_now) && !push) || forced || lost_start)
                frame_err <= 1'b1;
            if (hdr_now)
                evt_num <= evt_num + 8'd1;

            case (state)
                ST_IDLE: begin
                    if (eventStart) begin
                        state   <= ST_OPEN;
                        hit_cnt <= '0;
                        trunc   <= 1'b0;
                    end
                end
                ST_OPEN: begin
                    if (hdr_pend) begin
                        hdr_pend <= 1'b0;
                        hit_cnt  <= {8'd0, hit};
                        trunc    <= hit;
                        if (hit && drop_cnt != 16'hFFFF)
                            drop_cnt <= drop_cnt + 16'd1;
                    end else if (eventStart) begin
                        hdr_pend  <= 1'b1;
                        pend_bcid <= BCIDin;
                    end else if (hit) begin
                        if (hit_cnt != 9'd511)
                            hit_cnt <= hit_cnt + 9'd1;
                        if (!push) begin
                            trunc <= 1'b1;
                            if (drop_cnt != 16'hFFFF)
                                drop_cnt <= drop_cnt + 16'd1;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef FRAME_CRC_EN
    logic [7:0] crc_q, crc_seed, crc_next;

    assign crc_seed = hdr_now ? 8'h00 : crc_q;

    frame_crc8 u_crc (
        .crc_in  (crc_seed),
        .data    (wr_word),
        .crc_out (crc_next)
    );

    always_ff @(posedge clk) begin
        if (!resetn)
            crc_q <= 8'h00;
        else if (hdr_now)
            crc_q <= push ? crc_next : 8'h00;
        else if (data_now && push)
            crc_q <= crc_next;
    end

    assign crc_field = crc_q;
`else
    assign crc_field = 8'h00;
`endif

    assign dout_valid          = (count != '0);
    assign dout                = dout_valid ? mem[rptr] : '0;
    assign streamBufAlmostFull = almost_full;
    assign frameErr            = frame_err;
    assign dropCount           = drop_cnt;

endmodule
